fsm_bit_serializer: RTL

- Parallel-to-serial feeder that sits directly upstream of the pattern-detecting FSM and drives its single-bit `data` input.
- Accepts a word plus a bit length over a valid/ready handshake and shifts it out LSB-first, one bit per clock.
- Supports back-to-back words with no gap bit.
- The FSM's error output `E` is fed back on `halt`. While `halt` is high, the current word is aborted and no new word is accepted.

---
 rtl/fsm_bit_serializer.sv | 113 +++++++++++
 1 files changed

// File: rtl/fsm_bit_serializer.sv
// -----------------------------------------------------------------------------
// fsm_bit_serializer
//
// Parallel-to-serial feeder for the pattern-detecting FSM. A word and its bit
// length are taken over a valid/ready handshake and shifted out LSB-first, one
// bit per clock. Back-to-back words run with no gap bit. The FSM error output
// is fed back on `halt`, which aborts the word in flight and blocks new words.
//
// Ports:
//   clk         system clock, rising edge
//   arst        asynchronous reset, active-high
//   in_valid    word/length presented
//   in_ready    serializer can accept a word this cycle (combinational)
//   in_word     word to send, bit 0 first
//   in_len      number of bits to send (clamped to WIDTH, 0 = drop word)
//   halt        abort request from the FSM
//   data        serial bit to the FSM (registered)
//   data_valid  data carries a real bit this cycle (registered)
//   busy        a word is being shifted out
//   done        one-cycle pulse after the last bit of a word (registered)
//   aborted     one-cycle pulse after a halt abort (registered)
// -----------------------------------------------------------------------------
module fsm_bit_serializer #(
    parameter int WIDTH = 24,
    parameter int LEN_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_word,
    input  logic [LEN_W-1:0] in_len,
    input  logic             halt,
    output logic             data,
    output logic             data_valid,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [LEN_W-1:0] remaining;
    logic [LEN_W-1:0] eff_len;
    logic             last_bit;
    logic             accept;

    // Oversized lengths are clamped so the counter never exceeds the word.
    assign eff_len  = (in_len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : in_len;
    assign last_bit = (state == SHIFT) && (remaining == LEN_W'(1));

    // A new word may load while the final bit of the current one is on the
    // line, which keeps consecutive words contiguous.
    assign in_ready = !arst && !halt && ((state == IDLE) || last_bit);
    assign accept   = in_valid && in_ready;
    assign busy     = (state == SHIFT);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state      <= IDLE;
            shreg      <= '0;
            remaining  <= '0;
            data       <= 1'b0;
            data_valid <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            if ((state == SHIFT) && halt) begin
                // Abort wins over completion, even on the last bit.
                state      <= IDLE;
                shreg      <= '0;
                remaining  <= '0;
                data       <= 1'b0;
                data_valid <= 1'b0;
                aborted    <= 1'b1;
            end else if ((state == SHIFT) && !last_bit) begin
                data      <= shreg[0];
                shreg     <= shreg >> 1;
                remaining <= remaining - LEN_W'(1);
            end else begin
                // Idle, or finishing the last bit of the current word.
                if (last_bit) begin
                    done <= 1'b1;
                end
                if (accept && (eff_len != '0)) begin
                    state      <= SHIFT;
                    data       <= in_word[0];
                    data_valid <= 1'b1;
                    shreg      <= in_word >> 1;
                    remaining  <= eff_len;
                end else begin
                    // A zero-length word is consumed and reported as done.
                    if (accept) begin
                        done <= 1'b1;
                    end
                    state      <= IDLE;
                    shreg      <= '0;
                    remaining  <= '0;
                    data       <= 1'b0;
                    data_valid <= 1'b0;
                end
            end
        end
    end

endmodule
